// File: rtl/lct_quality_sched.sv
// Ranks the two LCTs of each bunch crossing by Run-3 quality through one shared
// evaluator and hands the ordered pair to the MPC stage over valid/ready.
module lct_quality_sched #(
  parameter int MXBXN  = 12,
  parameter int MXDROP = 8
) (
  input  logic              clock,
  input  logic              global_reset,
  input  logic              pair_vld,
  input  logic              lct0_a,
  input  logic              lct0_c,
  input  logic [2:0]        lct0_alct_nhit,
  input  logic [2:0]        lct0_clct_nhit,
  input  logic              lct1_a,
  input  logic              lct1_c,
  input  logic [2:0]        lct1_alct_nhit,
  input  logic [2:0]        lct1_clct_nhit,
  input  logic [MXBXN-1:0]  pair_bxn,
  output logic              pair_busy,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [1:0]        out_q0,
  output logic [1:0]        out_q1,
  output logic              out_swap,
  output logic [1:0]        out_nlct,
  output logic [MXBXN-1:0]  out_bxn,
  output logic [MXDROP-1:0] drop_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EVAL0 = 3'd1,
    EVAL1 = 3'd2,
    SORT  = 3'd3,
    SEND  = 3'd4
  } state_t;

  typedef struct packed {
    logic       a;
    logic       c;
    logic [2:0] alct_nhit;
    logic [2:0] clct_nhit;
  } lct_t;

  localparam logic [MXDROP-1:0] DROP_MAX = {MXDROP{1'b1}};
  localparam logic [MXDROP-1:0] DROP_ONE = {{(MXDROP-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_nxt_s;
  lct_t               buf_lct0_r;
  lct_t               buf_lct1_r;
  logic [MXBXN-1:0]   buf_bxn_r;
  logic               buf_full_r;
  lct_t               wrk_lct0_r;
  lct_t               wrk_lct1_r;
  logic [MXBXN-1:0]   wrk_bxn_r;
  logic [1:0]         q0_r;
  logic [1:0]         q1_r;
  logic               v0_r;
  logic               v1_r;
  lct_t               eval_in_s;
  logic [1:0]         eval_q_s;
  logic               eval_v_s;
  logic               accept_s;
  logic               swap_s;
  logic [2:0]         key0_s;
  logic [2:0]         key1_s;
  logic               out_vld_r;
  logic [1:0]         out_q0_r;
  logic [1:0]         out_q1_r;
  logic               out_swap_r;
  logic [1:0]         out_nlct_r;
  logic [MXBXN-1:0]   out_bxn_r;
  logic [MXDROP-1:0]  drop_cnt_r;

  // Quality of one LCT: the best hit count among the two detectors wins.
  function automatic logic [1:0] lct_quality(input lct_t l);
    logic [1:0] q;
    q = 2'd0;
    if (!(l.a && l.c)) begin
      q = 2'd0;
    end else if (l.alct_nhit == 3'd6 || l.clct_nhit == 3'd6) begin
      q = 2'd3;
    end else if (l.alct_nhit == 3'd5 || l.clct_nhit == 3'd5) begin
      q = 2'd2;
    end else if (l.alct_nhit == 3'd4 || l.clct_nhit == 3'd4) begin
      q = 2'd1;
    end else begin
      q = 2'd0;
    end
    return q;
  endfunction

  // Busy depends on registered state only, so there is no input-to-output path.
  assign pair_busy = buf_full_r && (state_r != IDLE);
  assign accept_s  = pair_vld && !pair_busy;

  // Shared evaluator input select.
  always_comb begin
    eval_in_s = wrk_lct1_r;
    if (state_r == EVAL0) begin
      eval_in_s = wrk_lct0_r;
    end else begin
      eval_in_s = wrk_lct1_r;
    end
  end

  assign eval_q_s = lct_quality(eval_in_s);
  assign eval_v_s = eval_in_s.a && eval_in_s.c;
  assign key0_s   = {v0_r, q0_r};
  assign key1_s   = {v1_r, q1_r};
  assign swap_s   = key1_s > key0_s;

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (buf_full_r) begin
          state_nxt_s = EVAL0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EVAL0: state_nxt_s = EVAL1;
      EVAL1: state_nxt_s = SORT;
      SORT:  state_nxt_s = SEND;
      SEND: begin
        if (out_rdy) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (global_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // One-deep input buffer; a same-cycle drain and accept leaves it full.
  always_ff @(posedge clock) begin
    if (global_reset) begin
      buf_full_r <= 1'b0;
      buf_lct0_r <= '0;
      buf_lct1_r <= '0;
      buf_bxn_r  <= '0;
    end else if (accept_s) begin
      buf_full_r <= 1'b1;
      buf_lct0_r <= '{lct0_a, lct0_c, lct0_alct_nhit, lct0_clct_nhit};
      buf_lct1_r <= '{lct1_a, lct1_c, lct1_alct_nhit, lct1_clct_nhit};
      buf_bxn_r  <= pair_bxn;
    end else if (state_r == IDLE && buf_full_r) begin
      buf_full_r <= 1'b0;
    end
  end

  // Saturating count of pairs refused while busy.
  always_ff @(posedge clock) begin
    if (global_reset) begin
      drop_cnt_r <= '0;
    end else if (pair_vld && pair_busy && drop_cnt_r != DROP_MAX) begin
      drop_cnt_r <= drop_cnt_r + DROP_ONE;
    end
  end

  // Working pair, per-LCT quality and ranked output registers.
  always_ff @(posedge clock) begin
    if (global_reset) begin
      wrk_lct0_r <= '0;
      wrk_lct1_r <= '0;
      wrk_bxn_r  <= '0;
      q0_r       <= 2'd0;
      q1_r       <= 2'd0;
      v0_r       <= 1'b0;
      v1_r       <= 1'b0;
      out_vld_r  <= 1'b0;
      out_q0_r   <= 2'd0;
      out_q1_r   <= 2'd0;
      out_swap_r <= 1'b0;
      out_nlct_r <= 2'd0;
      out_bxn_r  <= '0;
    end else begin
      out_vld_r <= (state_nxt_s == SEND);
      case (state_r)
        IDLE: begin
          if (buf_full_r) begin
            wrk_lct0_r <= buf_lct0_r;
            wrk_lct1_r <= buf_lct1_r;
            wrk_bxn_r  <= buf_bxn_r;
          end
        end
        EVAL0: begin
          q0_r <= eval_q_s;
          v0_r <= eval_v_s;
        end
        EVAL1: begin
          q1_r <= eval_q_s;
          v1_r <= eval_v_s;
        end
        SORT: begin
          out_swap_r <= swap_s;
          out_q0_r   <= swap_s ? q1_r : q0_r;
          out_q1_r   <= swap_s ? q0_r : q1_r;
          out_nlct_r <= {1'b0, v0_r} + {1'b0, v1_r};
          out_bxn_r  <= wrk_bxn_r;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_vld  = out_vld_r;
  assign out_q0   = out_q0_r;
  assign out_q1   = out_q1_r;
  assign out_swap = out_swap_r;
  assign out_nlct = out_nlct_r;
  assign out_bxn  = out_bxn_r;
  assign drop_cnt = drop_cnt_r;

endmodule
